// File: rtl/multi8_pkg.sv
// Shared constants and state type for the multi8 shift-add multiplier.
// Optional signed mode is selected by defining MULTI8_SIGNED_EN.
package multi8_pkg;

  localparam int unsigned W_DEF = 8;
  localparam int unsigned ITER  = W_DEF;
  localparam int unsigned CNT_W = $clog2(W_DEF + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/multi8_datapath.sv
// Operand registers, shift-add step and result register for multi8.
// With MULTI8_SIGNED_EN defined, magnitudes are multiplied and the result is negated on sign mismatch.
module multi8_datapath #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           last,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] z
);

  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_z;
  logic [W-1:0]   r_mplr;
  logic [2*W-1:0] w_addend;
  logic [2*W-1:0] w_acc_next;
  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic [2*W-1:0] w_result;

`ifdef MULTI8_SIGNED_EN
  logic r_neg;

  // The most negative operand maps onto itself, which is its correct unsigned magnitude.
  always_comb begin
    w_a_mag  = a[W-1] ? (~a + 1'b1) : a;
    w_b_mag  = b[W-1] ? (~b + 1'b1) : b;
    w_result = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (load) begin
      r_neg <= a[W-1] ^ b[W-1];
    end
  end
`else
  always_comb begin
    w_a_mag  = a;
    w_b_mag  = b;
    w_result = w_acc_next;
  end
`endif

  // The multiplicand shifts left with each step so it always sits at the current bit weight.
  always_comb begin
    w_addend   = r_mplr[0] ? r_mcand : '0;
    w_acc_next = r_acc + w_addend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_z     <= '0;
    end else if (load) begin
      r_mcand <= {{W{1'b0}}, w_a_mag};
      r_mplr  <= w_b_mag;
      r_acc   <= '0;
    end else if (step) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      if (last) begin
        r_z <= w_result;
      end
    end
  end

  assign z = r_z;

endmodule

// File: rtl/multi8.sv
// Sequential 8x8 shift-add multiplier with start/busy/done handshake; one partial product per clock.
// Define MULTI8_SIGNED_EN for two's-complement operands and product.
module multi8
  import multi8_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] z,
  output logic           busy,
  output logic           done
);

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  always_comb begin
    w_load = (r_state == IDLE) && start;
    w_step = (r_state == RUN);
    w_last = (r_count == CNT_W'(ITER - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_count <= '0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  multi8_datapath #(
    .W (W)
  ) u_datapath (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .step (w_step),
    .last (w_last),
    .a    (a),
    .b    (b),
    .z    (z)
  );

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_multi8.sv
// Self-checking bench for multi8: directed test-plan cases plus random operations
// checked against an arithmetic reference model (signed when MULTI8_SIGNED_EN is defined).
module tb_multi8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] z;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] z_model;

  multi8 u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .z     (z),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
`ifdef MULTI8_SIGNED_EN
    p = int'($signed(x)) * int'($signed(y));
`else
    p = int'(x) * int'(y);
`endif
    return p[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation at the current cycle; returns in the done cycle so a caller may chain.
  task automatic do_mul(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp,
                        input bit disturb);
    int  n;
    bit  got_done;
    start = 1'b1;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    check_eq("busy_after_start", {15'd0, busy}, 16'd1);
    n        = 1;
    got_done = 1'b0;
    while (n <= 20 && !got_done) begin
      check_eq("z_hold", z, z_model);
      check_eq("no_early_done", {15'd0, done}, 16'd0);
      if (disturb && n == 3) begin
        a     = ~x;
        b     = y + 8'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) got_done = 1'b1;
      else n++;
    end
    start = 1'b0;
    if (!got_done) begin
      check_eq("timeout", 16'd0, 16'd1);
    end else begin
      check_eq("latency", 16'(n), 16'd8);
      check_eq("busy_in_done", {15'd0, busy}, 16'd0);
      check_eq("product", z, exp);
      z_model = exp;
    end
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] zu;
  } vec_t;

  vec_t stream[7] = '{
    '{8'd4,   8'd0,  16'h0000},
    '{8'd20,  8'd16, 16'h0140},
    '{8'd133, 8'd18, 16'h095A},
    '{8'd149, 8'd18, 16'h0A7A},
    '{8'd144, 8'd26, 16'h0EA0},
    '{8'd145, 8'd17, 16'h09A1},
    '{8'd148, 8'd18, 16'h0A68}
  };

  function automatic logic [15:0] plan_exp(input vec_t v);
`ifdef MULTI8_SIGNED_EN
    return ref_mul(v.x, v.y);
`else
    return v.zu;
`endif
  endfunction

  initial begin
    logic [7:0] rx;
    logic [7:0] ry;
    bit         seen_done;
    rst     = 1'b1;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    z_model = '0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_z", z, 16'h0000);
    check_eq("reset_busy", {15'd0, busy}, 16'd0);
    check_eq("reset_done", {15'd0, done}, 16'd0);

    // 5 * 10, then confirm done lasts exactly one cycle
    do_mul(8'd5, 8'd10, 16'h0032, 1'b0);
    tick();
    check_eq("done_one_cycle", {15'd0, done}, 16'd0);
    check_eq("z_held_idle", z, 16'h0032);

    // Back-to-back stream, each started in the previous done cycle
    for (int i = 0; i < 7; i++) do_mul(stream[i].x, stream[i].y, plan_exp(stream[i]), 1'b0);
    tick();

`ifdef MULTI8_SIGNED_EN
    do_mul(8'hFF, 8'hFF, 16'h0001, 1'b0);
`else
    do_mul(8'hFF, 8'hFF, 16'hFE01, 1'b0);
`endif
    do_mul(8'h00, 8'h00, 16'h0000, 1'b0);
    tick();

    // Reset during the 4th RUN cycle aborts with no done pulse
    start = 1'b1;
    a     = 8'd133;
    b     = 8'd18;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    z_model = 16'h0000;
    check_eq("abort_busy", {15'd0, busy}, 16'd0);
    check_eq("abort_done", {15'd0, done}, 16'd0);
    check_eq("abort_z", z, 16'h0000);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check_eq("abort_no_done", {15'd0, seen_done}, 16'd0);
    check_eq("abort_z_held", z, 16'h0000);
    do_mul(8'd133, 8'd18, ref_mul(8'd133, 8'd18), 1'b0);
    tick();

    // Operand changes and start pulses during RUN are ignored
    do_mul(8'd77, 8'd201, ref_mul(8'd77, 8'd201), 1'b1);
    tick();

`ifdef MULTI8_SIGNED_EN
    do_mul(8'h85, 8'h12, 16'hF75A, 1'b0);
    do_mul(8'h80, 8'h80, 16'h4000, 1'b0);
    do_mul(8'hFF, 8'h01, 16'hFFFF, 1'b0);
    tick();
`endif

    // Random operations, sometimes chained, sometimes disturbed, with idle gaps
    for (int i = 0; i < 40; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      do_mul(rx, ry, ref_mul(rx, ry), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
        check_eq("rand_idle_z", z, z_model);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi8.md
Name: multi8

Overview:
- Sequential 8x8 shift-add multiplier; produces the 16-bit product z = a * b.
- Arithmetic building block of the 8-bit ALU; the ALU sequences operands through a start/done handshake.
- One partial product is accumulated per clock. Result is held on z until the next result replaces it.

Parameters:
- W, 8, operand width; product width is 2*W. Only W=8 is verified.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only while idle
- a  input  W  multiplicand; captured on the accepted start edge
- b  input  W  multiplier; captured on the accepted start edge
- z  output  2W  product; registered and held between results
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when z has just been updated

Interface decisions:
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- States: IDLE, RUN.
- Reset (rst=1 at a rising edge): state=IDLE, z=0, busy=0, done=0, internal accumulator and count cleared. Reset overrides start.
- Reset mid-operation aborts the operation. No done pulse is produced and z=0.
- IDLE: when start=1 at edge k:
  - latch a and b;
  - clear accumulator, count=0;
  - go to RUN, busy=1 after edge k.
- start while busy is ignored. Operands changing during RUN have no effect.
- RUN, edges k+1..k+8, one multiplier bit per edge, LSB first:
  - if the current multiplier bit is 1, add the multiplicand, shifted by the bit index, into the 2W accumulator;
  - 2W-bit accumulation; no overflow is possible.
- Edge k+8: z <= final product, done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency: start edge to z valid is 8 clocks. Throughput is one product per 8 cycles when restarted in the done cycle.
- Back-to-back: start=1 in the done cycle is accepted because busy=0, so a new operation begins.
- z changes only on reset or at edge k+8. Between results, z holds its last value.
- Zero operands run the full 8 cycles and give z=0.
- Default arithmetic is unsigned: 255*255 = 0xFE01.

Optional Feature:
- Macro MULTI8_SIGNED_EN.
- Defined:
  - a, b and z are two's complement.
  - Implementation: magnitudes are multiplied unsigned; the product is negated when the sign bits of a and b differ.
  - Latency stays 8 cycles.
  - -128 * -128 = 0x4000.
- Undefined: purely unsigned, with no sign logic synthesized.

Decomposition:
- Package multi8_pkg:
  - W_DEF=8;
  - state typedef {IDLE, RUN};
  - ITER = W (iteration count);
  - count width localparam $clog2(W+1).
- One natural sub-module, multi8_datapath:
  - operand registers, shift, add and accumulator;
  - controlled by load and step strobes from the top-level FSM.

Test Plan:
- a=5, b=10, start pulse -> done 8 cycles later, z=0x0032. busy high for exactly 8 cycles.
- Stream (a,b) = (4,0), (20,16), (133,18), (149,18), (144,26), (145,17), (148,18), each started in the previous done cycle -> z = 0x0000, 0x0140, 0x095A, 0x0A7A, 0x0EA0, 0x09A1, 0x0A68. done pulses every 8 cycles.
- a=255, b=255 -> z=0xFE01. Then start with a=0, b=0 -> z holds 0xFE01 until done, then becomes 0x0000.
- Assert rst at cycle 4 of a 133*18 run -> busy=0, done never pulses, z=0. A following start computes 133*18 correctly.
- Change a, b and pulse start during RUN -> ignored. Result reflects the latched operands.
- MULTI8_SIGNED_EN defined:
  - a=0x85, b=0x12 -> z=0xF75A (-2214);
  - a=0x80, b=0x80 -> z=0x4000;
  - a=0xFF, b=0x01 -> z=0xFFFF.
